// File: rtl/status_mon_pkg.sv
// Shared types and constants for the FP multiplier status checkers.
package status_mon_pkg;

   localparam int ZERO_IDX = 0;
   localparam int INF_IDX  = 1;
   localparam int NAN_IDX  = 2;
   localparam int TINY_IDX = 3;
   localparam int HUGE_IDX = 4;

   localparam logic [7:0] DEFAULT_EXCL_MASK = 8'h1F;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      FAULT    = 2'd2
   } mon_state_e;

endpackage

// File: rtl/excl_popcount_chk.sv
// Combinational detector: multi is high when more than one bit of vec is set.
module excl_popcount_chk #(
   parameter int W = 8
) (
   input  logic [W-1:0] vec,
   output logic         multi
);

   logic seen_one;

   always_comb begin
      seen_one = 1'b0;
      multi    = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) begin
            if (seen_one) multi = 1'b1;
            seen_one = 1'b1;
         end
      end
   end

endmodule

// File: rtl/status_excl_monitor.sv
// Observational checker for mutually exclusive FP status flags with sticky/count/capture state.
// Optional assertions are compiled in with STATUS_EXCL_MON_SVA_EN.
//
// state    | meaning
// DISARMED | skipping the first ARM_DLY valid samples after reset/clear
// ARMED    | checking samples, no violation seen yet
// FAULT    | at least one violation captured; first_* frozen
module status_excl_monitor
   import status_mon_pkg::*;
#(
   parameter int                  W_STATUS  = 8,
   parameter logic [W_STATUS-1:0] EXCL_MASK = W_STATUS'(DEFAULT_EXCL_MASK),
   parameter int                  CNT_W     = 16,
   parameter int                  ARM_DLY   = 2,
   parameter int                  ALARM_TH  = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                status_vld_i,
   input  logic [W_STATUS-1:0] status_i,
   input  logic                clr_i,
   output logic                viol_pulse_o,
   output logic                err_sticky_o,
   output logic                alarm_o,
   output logic [CNT_W-1:0]    viol_cnt_o,
   output logic [W_STATUS-1:0] first_status_o,
   output logic [CNT_W-1:0]    first_time_o,
   output logic [W_STATUS-1:0] seen_mask_o,
   output logic [1:0]          state_o
);

   localparam int               ARM_W      = (ARM_DLY < 1) ? 1 : $clog2(ARM_DLY + 1);
   localparam logic [ARM_W-1:0] ARM_DLY_C  = ARM_W'(ARM_DLY);
   localparam logic [CNT_W-1:0] ALARM_TH_C = CNT_W'(ALARM_TH);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   mon_state_e          state_q, state_d;
   logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d, arm_inc;
   logic [CNT_W-1:0]    ts_q, ts_d;
   logic                pulse_q, pulse_d;
   logic                sticky_q, sticky_d;
   logic                alarm_q, alarm_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [W_STATUS-1:0] first_status_q, first_status_d;
   logic [CNT_W-1:0]    first_time_q, first_time_d;
   logic [W_STATUS-1:0] seen_q, seen_d;

   logic [W_STATUS-1:0] stat_m;
   logic                multi;
   logic                chk_en;
   logic                checked;
   logic                viol;

   assign stat_m = status_i & EXCL_MASK;

   excl_popcount_chk #(.W(W_STATUS)) u_popcount (
      .vec   (stat_m),
      .multi (multi)
   );

   // With no arming delay every sample is checked, even the one on the arming edge.
   assign chk_en  = (state_q != DISARMED) || (ARM_DLY == 0);
   assign checked = status_vld_i && chk_en && !clr_i;
   assign viol    = checked && multi;
   assign arm_inc = arm_cnt_q + ARM_W'(1);

   always_comb begin
      state_d        = state_q;
      arm_cnt_d      = arm_cnt_q;
      ts_d           = ts_q + CNT_W'(1);
      pulse_d        = viol;
      sticky_d       = sticky_q;
      cnt_d          = cnt_q;
      first_status_d = first_status_q;
      first_time_d   = first_time_q;
      seen_d         = seen_q;

      if (clr_i) begin
         state_d        = DISARMED;
         arm_cnt_d      = '0;
         sticky_d       = 1'b0;
         cnt_d          = '0;
         first_status_d = '0;
         first_time_d   = '0;
         seen_d         = '0;
      end else begin
         if (checked) seen_d = seen_q | stat_m;
         if (viol) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (!sticky_q) begin
               first_status_d = status_i;
               first_time_d   = ts_q;
            end
            state_d = FAULT;
         end else if (state_q == DISARMED) begin
            if (ARM_DLY == 0) begin
               state_d = ARMED;
            end else if (status_vld_i) begin
               arm_cnt_d = arm_inc;
               if (arm_inc == ARM_DLY_C) state_d = ARMED;
            end
         end
      end

      alarm_d = (cnt_d >= ALARM_TH_C);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= DISARMED;
         arm_cnt_q      <= '0;
         ts_q           <= '0;
         pulse_q        <= 1'b0;
         sticky_q       <= 1'b0;
         alarm_q        <= 1'b0;
         cnt_q          <= '0;
         first_status_q <= '0;
         first_time_q   <= '0;
         seen_q         <= '0;
      end else begin
         state_q        <= state_d;
         arm_cnt_q      <= arm_cnt_d;
         ts_q           <= ts_d;
         pulse_q        <= pulse_d;
         sticky_q       <= sticky_d;
         alarm_q        <= alarm_d;
         cnt_q          <= cnt_d;
         first_status_q <= first_status_d;
         first_time_q   <= first_time_d;
         seen_q         <= seen_d;
      end
   end

   assign viol_pulse_o   = pulse_q;
   assign err_sticky_o   = sticky_q;
   assign alarm_o        = alarm_q;
   assign viol_cnt_o     = cnt_q;
   assign first_status_o = first_status_q;
   assign first_time_o   = first_time_q;
   assign seen_mask_o    = seen_q;
   assign state_o        = state_q;

`ifdef STATUS_EXCL_MON_SVA_EN
   for (genvar gi = 0; gi < W_STATUS; gi++) begin : g_pair_i
      for (genvar gj = gi + 1; gj < W_STATUS; gj++) begin : g_pair_j
         if (EXCL_MASK[gi] && EXCL_MASK[gj]) begin : g_chk
            a_excl_pair : assert property (@(posedge clk_i) disable iff (!rst_ni)
               !(checked && status_i[gi] && status_i[gj]))
               else $error("status_excl_monitor: bits %0d and %0d set together", gi, gj);
         end
      end
   end

   a_cnt_monotonic : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !clr_i |=> (cnt_q >= $past(cnt_q)))
      else $error("status_excl_monitor: viol_cnt decreased without clr");
`endif

endmodule

// File: tb/tb_status_excl_monitor.sv
// Directed bench for status_excl_monitor: one default-width instance and one narrow-counter instance.
module tb_status_excl_monitor;
   import status_mon_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic [7:0]  status;
   logic        clr;

   logic        a_pulse, a_sticky, a_alarm;
   logic [15:0] a_cnt, a_ftime;
   logic [7:0]  a_fstat, a_seen;
   logic [1:0]  a_state;

   logic        b_pulse, b_sticky, b_alarm;
   logic [3:0]  b_cnt, b_ftime;
   logic [7:0]  b_fstat, b_seen;
   logic [1:0]  b_state;

   int checks   = 0;
   int failures = 0;
   int ts_exp   = 0;
   int t_cap;

   always #5 clk = ~clk;

   status_excl_monitor #(
      .W_STATUS(8), .EXCL_MASK(8'h1F), .CNT_W(16), .ARM_DLY(2), .ALARM_TH(3)
   ) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .status_vld_i(vld), .status_i(status), .clr_i(clr),
      .viol_pulse_o(a_pulse), .err_sticky_o(a_sticky), .alarm_o(a_alarm),
      .viol_cnt_o(a_cnt), .first_status_o(a_fstat), .first_time_o(a_ftime),
      .seen_mask_o(a_seen), .state_o(a_state)
   );

   status_excl_monitor #(
      .W_STATUS(8), .EXCL_MASK(8'h1F), .CNT_W(4), .ARM_DLY(0), .ALARM_TH(1)
   ) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .status_vld_i(vld), .status_i(status), .clr_i(clr),
      .viol_pulse_o(b_pulse), .err_sticky_o(b_sticky), .alarm_o(b_alarm),
      .viol_cnt_o(b_cnt), .first_status_o(b_fstat), .first_time_o(b_ftime),
      .seen_mask_o(b_seen), .state_o(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: t_cap holds the timestamp seen by the edge, outputs sampled 1 time unit later.
   task automatic step();
      t_cap = ts_exp;
      @(posedge clk);
      #1;
      ts_exp++;
   endtask

   initial begin
      rst_n  = 1'b0;
      vld    = 1'b0;
      status = 8'h00;
      clr    = 1'b0;
      #12;
      chk("rst_state",  32'(a_state),  32'(DISARMED));
      chk("rst_cnt",    32'(a_cnt),    32'h0);
      chk("rst_sticky", 32'(a_sticky), 32'h0);
      chk("rst_fstat",  32'(a_fstat),  32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // arming: two unchecked samples, then checking begins
      vld = 1'b1; status = 8'h01;
      step();
      chk("arm_s1_state", 32'(a_state), 32'(DISARMED));
      chk("arm_s1_seen",  32'(a_seen),  32'h00);
      step();
      chk("arm_s2_state", 32'(a_state), 32'(ARMED));
      step(); step(); step();
      chk("arm_cnt",  32'(a_cnt),  32'h0);
      chk("arm_seen", 32'(a_seen), 32'h01);

      // first violation: inf+nan
      status = 8'h06;
      step();
      chk("v1_pulse",  32'(a_pulse),  32'h1);
      chk("v1_sticky", 32'(a_sticky), 32'h1);
      chk("v1_cnt",    32'(a_cnt),    32'h1);
      chk("v1_fstat",  32'(a_fstat),  32'h06);
      chk("v1_ftime",  32'(a_ftime),  32'(t_cap));
      chk("v1_state",  32'(a_state),  32'(FAULT));
      chk("v1_alarm",  32'(a_alarm),  32'h0);
      vld = 1'b0;
      step();
      chk("v1_pulse_off", 32'(a_pulse), 32'h0);

      // further violations in FAULT; alarm at the third
      vld = 1'b1; status = 8'h18;
      step();
      chk("v2_cnt",   32'(a_cnt),   32'h2);
      chk("v2_alarm", 32'(a_alarm), 32'h0);
      status = 8'h03;
      step();
      chk("v3_pulse", 32'(a_pulse), 32'h1);
      chk("v3_cnt",   32'(a_cnt),   32'h3);
      chk("v3_alarm", 32'(a_alarm), 32'h1);
      chk("v3_fstat", 32'(a_fstat), 32'h06);

      // bits outside the mask and invalid cycles never violate
      status = 8'hE1;
      step();
      chk("oom_pulse", 32'(a_pulse), 32'h0);
      chk("oom_cnt",   32'(a_cnt),   32'h3);
      vld = 1'b0; status = 8'hFF;
      step();
      chk("inv_pulse", 32'(a_pulse), 32'h0);
      chk("inv_cnt",   32'(a_cnt),   32'h3);
      chk("seen_all",  32'(a_seen),  32'h1F);

      // clr beats a simultaneous violation
      clr = 1'b1; vld = 1'b1; status = 8'h05;
      step();
      chk("clr_pulse",  32'(a_pulse),  32'h0);
      chk("clr_cnt",    32'(a_cnt),    32'h0);
      chk("clr_sticky", 32'(a_sticky), 32'h0);
      chk("clr_alarm",  32'(a_alarm),  32'h0);
      chk("clr_fstat",  32'(a_fstat),  32'h00);
      chk("clr_seen",   32'(a_seen),   32'h00);
      chk("clr_state",  32'(a_state),  32'(DISARMED));
      clr = 1'b0;
      step();
      chk("rearm_s1_pulse", 32'(a_pulse), 32'h0);
      step();
      chk("rearm_s2_pulse", 32'(a_pulse), 32'h0);
      chk("rearm_s2_state", 32'(a_state), 32'(ARMED));
      step();
      chk("rearm_chk_pulse", 32'(a_pulse), 32'h1);
      chk("rearm_chk_cnt",   32'(a_cnt),   32'h1);
      chk("rearm_chk_fstat", 32'(a_fstat), 32'h05);

      // narrow counter saturation, then async reset mid-burst
      vld = 1'b0; status = 8'h00;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      ts_exp = 0;
      vld = 1'b1; status = 8'h03;
      for (int i = 0; i < 14; i++) step();
      chk("b_cnt_14",   32'(b_cnt),   32'hE);
      chk("b_alarm",    32'(b_alarm), 32'h1);
      chk("b_fstat",    32'(b_fstat), 32'h03);
      for (int i = 0; i < 6; i++) step();
      chk("b_cnt_sat",  32'(b_cnt),   32'hF);
      chk("b_pulse",    32'(b_pulse), 32'h1);
      chk("b_state",    32'(b_state), 32'(FAULT));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_b_cnt",    32'(b_cnt),    32'h0);
      chk("arst_b_pulse",  32'(b_pulse),  32'h0);
      chk("arst_b_sticky", 32'(b_sticky), 32'h0);
      chk("arst_b_state",  32'(b_state),  32'(DISARMED));
      chk("arst_a_cnt",    32'(a_cnt),    32'h0);
      chk("arst_a_seen",   32'(a_seen),   32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
